// File: rtl/mrisc_pkg.sv
// Shared execute-stage definitions: FSM encodings and datapath defaults.
package mrisc_pkg;

  localparam int unsigned DATA_W_DEF         = 32;
  localparam int unsigned BITS_PER_CYCLE_DEF = 4;

  // Control states for multi-cycle execute units.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : mrisc_pkg

// File: rtl/bit_select_unit_chunk_select.sv
// Combinational chunk scan for bit_select_unit.
// Ports:
//   chunk [BITS_PER_CYCLE-1:0]  bits of the current chunk, LSB first
//   need  [RANK_W-1:0]          1-based rank of the set bit wanted inside this chunk
//   pop   [PCNT_W-1:0]          number of set bits in the chunk
//   hit                         the need-th set bit lies in this chunk
//   idx   [POS_W-1:0]           position of that bit inside the chunk (0 when no hit)
module chunk_select #(
  parameter int unsigned BITS_PER_CYCLE = 4,
  parameter int unsigned RANK_W         = 6,
  parameter int unsigned PCNT_W         = 3,
  parameter int unsigned POS_W          = 2
) (
  input  logic [BITS_PER_CYCLE-1:0] chunk,
  input  logic [RANK_W-1:0]         need,
  output logic [PCNT_W-1:0]         pop,
  output logic                      hit,
  output logic [POS_W-1:0]          idx
);

  // Running count from the LSB; the first bit where the count reaches need is the hit.
  // need==0 never matches, so a zero need can't produce a false hit.
  always_comb begin
    pop = '0;
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (chunk[i]) begin
        pop = pop + PCNT_W'(1);
        if (!hit && (RANK_W'(pop) == need)) begin
          hit = 1'b1;
          idx = POS_W'(i);
        end
      end
    end
  end

endmodule : chunk_select

// File: rtl/bit_select_unit.sv
// Select unit: returns the bit index of the rank-th set bit of src1 (LSB first),
// scanning BITS_PER_CYCLE bits per clock and stopping at the first hit.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start             request, accepted only in IDLE
//   src1 [DATA_W-1:0] word to search
//   rank [RANK_W-1:0] 1-based rank of the wanted set bit
//   busy              high while scanning and in the done cycle
//   done              one-cycle result strobe
//   found             rank-th set bit exists
//   sel_idx [IDX_W-1:0] index of that bit, 0 when not found
module bit_select_unit
  import mrisc_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned BITS_PER_CYCLE = BITS_PER_CYCLE_DEF,
  parameter int unsigned IDX_W          = $clog2(DATA_W),
  parameter int unsigned RANK_W         = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] src1,
  input  logic [RANK_W-1:0] rank,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [IDX_W-1:0]  sel_idx
);

  localparam int unsigned NCHUNK  = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned PCNT_W  = $clog2(BITS_PER_CYCLE + 1);
  localparam int unsigned POS_W   = (BITS_PER_CYCLE > 1) ? $clog2(BITS_PER_CYCLE) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NCHUNK - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   src_q, src_d;
  logic [RANK_W-1:0]   rank_q, rank_d;
  logic [RANK_W-1:0]   cnt_q, cnt_d;
  logic [CHUNK_W-1:0]  chunk_q, chunk_d;
  logic                busy_d, done_d, found_d;
  logic [IDX_W-1:0]    sel_idx_d;

  logic [BITS_PER_CYCLE-1:0] chunk_bits;
  logic [RANK_W-1:0]         need;
  logic [PCNT_W-1:0]         chunk_pop;
  logic                      chunk_hit;
  logic [POS_W-1:0]          chunk_idx;

  // Current chunk and the rank still outstanding; cnt_q < rank_q whenever scanning.
  always_comb begin
    chunk_bits = src_q[32'(chunk_q) * BITS_PER_CYCLE +: BITS_PER_CYCLE];
    need       = rank_q - cnt_q;
  end

  chunk_select #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .RANK_W         (RANK_W),
    .PCNT_W         (PCNT_W),
    .POS_W          (POS_W)
  ) u_chunk_select (
    .chunk (chunk_bits),
    .need  (need),
    .pop   (chunk_pop),
    .hit   (chunk_hit),
    .idx   (chunk_idx)
  );

  // Next-state and next-register values.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    rank_d    = rank_q;
    cnt_d     = cnt_q;
    chunk_d   = chunk_q;
    found_d   = found;
    sel_idx_d = sel_idx;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d     = src1;
          rank_d    = rank;
          cnt_d     = '0;
          chunk_d   = '0;
          found_d   = 1'b0;
          sel_idx_d = '0;
          state_d   = (rank == '0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (chunk_hit) begin
          found_d   = 1'b1;
          sel_idx_d = IDX_W'(chunk_q) * IDX_W'(BITS_PER_CYCLE) + IDX_W'(chunk_idx);
          state_d   = S_DONE;
        end else if (chunk_q == LAST_CHUNK) begin
          found_d   = 1'b0;
          sel_idx_d = '0;
          state_d   = S_DONE;
        end else begin
          cnt_d   = cnt_q + RANK_W'(chunk_pop);
          chunk_d = chunk_q + CHUNK_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the upcoming state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      rank_q  <= '0;
      cnt_q   <= '0;
      chunk_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      sel_idx <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      rank_q  <= rank_d;
      cnt_q   <= cnt_d;
      chunk_q <= chunk_d;
      busy    <= busy_d;
      done    <= done_d;
      found   <= found_d;
      sel_idx <= sel_idx_d;
    end
  end

endmodule : bit_select_unit

// File: tb/tb_bit_select_unit.sv
// Bench for bit_select_unit: driver pushes expected results into a scoreboard queue,
// a negedge monitor pops and compares on every done pulse.
module tb_bit_select_unit;

  localparam int unsigned N_RANDOM = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src1;
  logic [5:0]  rank;
  logic        busy;
  logic        done;
  logic        found;
  logic [4:0]  sel_idx;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        found;
    logic [4:0]  idx;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur;
  logic done_prev = 1'b0;

  bit_select_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .src1    (src1),
    .rank    (rank),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .sel_idx (sel_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: walk the word LSB first, counting set bits until the rank-th one.
  // Latency: 1 for rank 0, chunk+2 on a hit, chunks+1 on a miss.
  function automatic void model(input logic [31:0] s, input logic [5:0] r,
                                output logic f, output logic [4:0] ix,
                                output int unsigned lat);
    int seen;
    seen = 0;
    f    = 1'b0;
    ix   = 5'd0;
    lat  = 32 / 4 + 1;
    if (r == 6'd0) begin
      lat = 1;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (s[i]) begin
          seen++;
          if (!f && seen == int'(r)) begin
            f   = 1'b1;
            ix  = 5'(i);
            lat = int'(i / 4) + 2;
          end
        end
      end
    end
  endfunction

  // Issue one request at the current negedge (DUT idle). While the request is in flight,
  // start and operands are scrambled when noisy is set; those starts must be ignored.
  task automatic issue(input logic [31:0] s, input logic [5:0] r, input bit noisy);
    logic        f;
    logic [4:0]  ix;
    int unsigned lat;
    exp_t        e;
    model(s, r, f, ix, lat);
    e.found = f;
    e.idx   = ix;
    e.cyc   = cyc + lat;
    exp_q.push_back(e);
    start = 1'b1;
    src1  = s;
    rank  = r;
    for (int unsigned k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      src1  = $urandom;
      rank  = 6'($urandom_range(0, 33));
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_flight src=%h rank=%0d k=%0d got=%b want=1", s, r, k, busy);
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done src=%h rank=%0d got=%b want=0", s, r, busy);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      checks++;
      if (done_prev === 1'b1) begin
        errors++;
        $display("FAIL done_width got=2+ cycles want=1 cycle at cyc=%0d", cyc);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cyc=%0d got done=1 want done=0", cyc);
      end else begin
        exp_cur = exp_q.pop_front();
        checks++;
        if (found !== exp_cur.found || sel_idx !== exp_cur.idx) begin
          errors++;
          $display("FAIL result got found=%b idx=%0d want found=%b idx=%0d",
                   found, sel_idx, exp_cur.found, exp_cur.idx);
        end
        checks++;
        if (cyc != exp_cur.cyc) begin
          errors++;
          $display("FAIL latency done at cyc=%0d want cyc=%0d", cyc, exp_cur.cyc);
        end
      end
    end
    done_prev = done;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    logic [5:0]  r;

    rst_n = 1'b0;
    start = 1'b0;
    src1  = '0;
    rank  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    checks++;
    if ({busy, done, found, sel_idx} !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b found=%b idx=%0d want all 0",
               busy, done, found, sel_idx);
    end

    // Directed cases
    issue(32'h0000_0001, 6'd1,  1'b0);
    issue(32'h8000_0000, 6'd1,  1'b0);
    issue(32'hFFFF_FFFF, 6'd17, 1'b0);
    issue(32'hFFFF_FFFF, 6'd32, 1'b0);
    issue(32'hFFFF_FFFF, 6'd33, 1'b0);
    issue(32'h0000_00F0, 6'd5,  1'b0);
    issue(32'h0000_00F0, 6'd0,  1'b0);
    issue(32'h0000_0F00, 6'd3,  1'b1);
    issue(32'h1234_5678, 6'd13, 1'b1);

    // Reset in the middle of a scan: no done may follow
    start = 1'b1;
    src1  = 32'h8000_0000;
    rank  = 6'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, found, sel_idx} !== 8'd0) begin
      errors++;
      $display("FAIL midscan_reset got busy=%b done=%b found=%b idx=%0d want all 0",
               busy, done, found, sel_idx);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet got done=%b busy=%b want 0 0", done, busy);
      end
    end
    issue(32'h0000_0100, 6'd1, 1'b0);

    // Random back-to-back requests with a mix of bit densities
    for (int n = 0; n < int'(N_RANDOM); n++) begin
      s = $urandom;
      case ($urandom_range(0, 3))
        0: s = s & $urandom & $urandom;
        1: s = s | $urandom;
        default: ;
      endcase
      r = 6'($urandom_range(0, 33));
      issue(s, r, 1'($urandom_range(0, 1)));
    end

    start = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending results want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bit_select_unit
